// File: rtl/writeback_queue_if.sv
// writeback_queue_if: memory-stage input, control-unit stalls, register-file head port and bypass lookups of the writeback queue
interface writeback_queue_if #(
    parameter int REGNO_W = 5,
    parameter int REG_W   = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
);
    logic               exec_stall, mem_stall, fetch_stall, nullify;
    logic               valid;
    logic [REGNO_W-1:0] rd_no;
    logic [REG_W-1:0]   rd_val;
    logic               full, empty;
    logic [CNT_W-1:0]   count;
    logic               rf_we, rf_gnt;
    logic [REGNO_W-1:0] head_no;
    logic [REG_W-1:0]   head_val;
    logic [REGNO_W-1:0] rs_no, rt_no;
    logic               rs_hit, rt_hit;
    logic [REG_W-1:0]   rs_val, rt_val;
    modport master (
        output exec_stall, mem_stall, fetch_stall, nullify, valid, rd_no, rd_val, rf_gnt, rs_no, rt_no,
        input  full, empty, count, rf_we, head_no, head_val, rs_hit, rt_hit, rs_val, rt_val
    );
    modport slave (
        input  exec_stall, mem_stall, fetch_stall, nullify, valid, rd_no, rd_val, rf_gnt, rs_no, rt_no,
        output full, empty, count, rf_we, head_no, head_val, rs_hit, rt_hit, rs_val, rt_val
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order retire queue feeding the register file write port, with youngest-match bypass lookups
module writeback_queue #(
    parameter int REGNO_W = 5,
    parameter int REG_W   = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic nrst,
    writeback_queue_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [REGNO_W-1:0] ent_no  [DEPTH];
    logic [REG_W-1:0]   ent_val [DEPTH];
    logic [DEPTH-1:0]   ent_vld;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, idx;
    logic [CNT_W-1:0]   count;
    logic               core_stall, push, pop;
    assign core_stall = wb.exec_stall | wb.mem_stall | wb.fetch_stall;
    assign push = wb.valid & ~core_stall & ~wb.nullify & ~wb.full & (wb.rd_no != '0);
    assign pop  = wb.rf_we & wb.rf_gnt;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            count  <= count + CNT_W'(push) - CNT_W'(pop);
            for (int k = 0; k < DEPTH; k++)
                ent_vld[k] <= (push && wr_ptr == PTR_W'(k)) || (ent_vld[k] && !(pop && rd_ptr == PTR_W'(k)));
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            ent_no[wr_ptr]  <= wb.rd_no;
            ent_val[wr_ptr] <= wb.rd_val;
        end
    end
    assign wb.count    = count;
    assign wb.full     = count == CNT_W'(DEPTH);
    assign wb.empty    = count == '0;
    assign wb.rf_we    = count != '0;
    assign wb.head_no  = count == '0 ? '0 : ent_no[rd_ptr];
    assign wb.head_val = count == '0 ? '0 : ent_val[rd_ptr];
    // walk oldest to youngest so the last match wins
    always_comb begin
        wb.rs_hit = 1'b0;
        wb.rs_val = '0;
        wb.rt_hit = 1'b0;
        wb.rt_val = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (ent_vld[idx] && wb.rs_no != '0 && ent_no[idx] == wb.rs_no) begin
                wb.rs_hit = 1'b1;
                wb.rs_val = ent_val[idx];
            end
            if (ent_vld[idx] && wb.rt_no != '0 && ent_no[idx] == wb.rt_no) begin
                wb.rt_hit = 1'b1;
                wb.rt_val = ent_val[idx];
            end
        end
    end
endmodule
